jk_bank_arbiter: RTL
====================

# jk_bank_arbiter

Round-robin arbiter and sequencer for a bank of clocked JK storage cells shared by several requesters. Each requester posts a J/K command (hold, reset, set or toggle) for one cell address. The block grants one requester at a time, drives that cell's enable and J/K inputs for exactly one cycle, and exposes the bank's q/qbar. It replaces free-running level-sensitive JK latches wherever several agents must update shared flag bits without races.

## Interface
Parameters:
- NREQ, 4 — number of requesters (2..8)
- NCELL, 8 — number of JK cells in the bank
- AW, 3 — cell address width; NCELL ≤ 2**AW

Ports:
- clk  in  1  — single clock; all state changes on rising edge
- rst  in  1  — asynchronous, active-high reset
- req  in  NREQ  — per-requester request level; held until granted
- req_addr  in  NREQ*AW  — cell address of requester i at bits [i*AW +: AW]
- req_jk  in  NREQ*2  — {j,k} of requester i at bits [i*2 +: 2]
- gnt  out  NREQ  — one-hot grant pulse, one cycle
- busy  out  1  — high whenever the FSM is not in IDLE
- err  out  1  — one-cycle pulse: granted address ≥ NCELL
- q  out  NCELL  — cell outputs
- qbar  out  NCELL  — always ~q
- op_cnt  out  8  — count of completed commands, wraps 255→0

## Operation
- FSM states: IDLE, APPLY, COOL.
- IDLE: if any req bit is set, select the winner by round-robin. Search starts at ptr and ascends modulo NREQ. Latch the winner's addr and jk, set gnt[winner], go to APPLY. If no req bit is set, stay in IDLE.
- APPLY: gnt is high this cycle only. en of the latched cell is 1. j and k are driven from the latched jk. At the closing edge:
  - 00: cell holds.
  - 01: cell is cleared to 0.
  - 10: cell is set to 1.
  - 11: cell toggles.
  - op_cnt increments.
  - ptr becomes winner+1 mod NREQ.
  - Go to COOL.
- COOL: one idle cycle, gnt=0, then return to IDLE. The granted requester must drop req during APPLY or COOL. req is sampled only in IDLE.
- Out-of-range address: grant is still issued and op_cnt still increments. No cell is enabled. err pulses high during APPLY.
- Non-selected cells always have en=0 and hold their value.
- A toggle is a clean edge-triggered single inversion. There is no oscillation and no delay element.
- Reset (asynchronous, any state, including mid-APPLY):
  - Outputs: q=0, qbar=all 1, gnt=0, err=0, busy=0, op_cnt=0.
  - Internal: ptr=0, state=IDLE.
  - An in-flight command is discarded and is not re-issued.

## Timing
- A request seen in IDLE at edge t produces: gnt and busy high in cycle t+1, new q visible after edge t+2, back in IDLE at cycle t+3.
- Throughput is one command per 3 cycles while requests are pending.
- Back-to-back commands to the same cell are applied in grant order. Two toggles restore the original value.
- When several requesters are simultaneously active, the lowest index at or above ptr wins.
- qbar tracks q combinationally. q, gnt, err, busy and op_cnt are registered.

## Structure
- Shared package jk_pkg holds:
  - Command localparams: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
  - FSM state encoding: IDLE=2'd0, APPLY=2'd1, COOL=2'd2.
- Sub-module jk_cell: one clocked JK flop with ports clk, rst (async, active-high), en, j, k, q, qbar. It is instantiated NCELL times via generate.
- The arbiter, FSM, ptr and op_cnt live in the top module.

## Test plan
- Reset, then req=4'b0001, addr0=3, jk0=10 → gnt=0001 for one cycle at t+1, q=8'h08 after t+2, op_cnt=1, busy low at t+3.
- req=4'b1111 held with ptr=0 and all jk=11 on different addrs 0..3 → grants in order 0001, 0010, 0100, 1000, each 3 cycles apart; q=8'h0F; op_cnt=4.
- Cell 5 set, then two toggles from requester 2 → q[5] sequence 1→0→1; qbar[5] is always the inverse.
- NCELL=6, addr=7, jk=10 → gnt pulses, err=1 in APPLY, q unchanged, op_cnt increments.
- Assert rst asynchronously mid-APPLY with q=8'hFF → immediately q=0, qbar=8'hFF, gnt=0, op_cnt=0; the next grant goes to requester 0 if it is active.
- 256 commands → op_cnt wraps to 0 with no err pulse.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: JK command codes and the
// sequencer's state encoding.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        COOL  = 2'd2
    } state_t;

endpackage

// File: rtl/jk_cell.sv
// One edge-triggered JK storage cell. It changes only on a rising edge with
// en high, so a toggle is a single clean inversion.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                JK_HOLD: q_q <= q_q;
                JK_CLR:  q_q <= 1'b0;
                JK_SET:  q_q <= 1'b1;
                default: q_q <= ~q_q;
            endcase
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer (IDLE -> APPLY -> COOL) that
// applies one requester's JK command to one cell of a shared bank.
//
// Handshake: req[i] is a level that the requester holds until it sees gnt[i];
// gnt[i] is a one-cycle pulse and req[i] must be dropped during APPLY or COOL.
// req is only sampled in IDLE, so a request is never granted twice.
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NCELL = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*2-1:0]    req_jk,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 err,
    output logic [NCELL-1:0]     q,
    output logic [NCELL-1:0]     qbar,
    output logic [7:0]           op_cnt,
    output logic [1:0]           dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;
    logic [AW-1:0]   addr_q;
    logic [1:0]      jk_q;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;
    logic            err_q;
    logic [7:0]      op_cnt_q;

    logic            win_found_d;
    logic [PW-1:0]   win_idx_d;
    logic [AW-1:0]   sel_addr_d;
    logic [1:0]      sel_jk_d;

    // Search starts at ptr and wraps, so the lowest index at or above ptr wins.
    always_comb begin
        int idx;
        idx         = 0;
        win_found_d = 1'b0;
        win_idx_d   = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr_q) + off) % NREQ;
            if (!win_found_d && req[idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = PW'(idx);
            end
        end
        sel_addr_d = req_addr[win_idx_d*AW +: AW];
        sel_jk_d   = req_jk[win_idx_d*2 +: 2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            addr_q   <= '0;
            jk_q     <= JK_HOLD;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            op_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q   <= APPLY;
                        win_q     <= win_idx_d;
                        addr_q    <= sel_addr_d;
                        jk_q      <= sel_jk_d;
                        gnt_q     <= NREQ'(1) << win_idx_d;
                        busy_q    <= 1'b1;
                        err_q     <= (int'(sel_addr_d) >= NCELL);
                    end
                end
                APPLY: begin
                    state_q  <= COOL;
                    gnt_q    <= '0;
                    err_q    <= 1'b0;
                    op_cnt_q <= op_cnt_q + 8'd1;
                    ptr_q    <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
                COOL: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range addresses match no cell, so nothing is enabled for them.
    for (genvar i = 0; i < NCELL; i++) begin : g_cell
        logic cell_en;
        assign cell_en = (state_q == APPLY) && (int'(addr_q) == i);

        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (cell_en),
            .j    (jk_q[1]),
            .k    (jk_q[0]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign op_cnt    = op_cnt_q;
    assign dbg_state = state_q;

endmodule
